// File: rtl/pong_round_ctrl.sv
// Round sequencer for the two-player paddle game: steps idle/serve/play/scored/game-over,
// keeps both scores and gates paddle/ball motion from frame, start and round-winner events.
module pong_round_ctrl #(
    parameter int WIN_SCORE    = 5,
    parameter int SERVE_FRAMES = 120,
    parameter int SCORE_FRAMES = 60,
    parameter int SCORE_W      = 3,
    parameter int CNT_W        = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               frame_tick,
    input  logic               start_btn,
    input  logic [2:0]         winner,
    output logic [2:0]         state,
    output logic               play_en,
    output logic               ball_rst,
    output logic [SCORE_W-1:0] p1_score,
    output logic [SCORE_W-1:0] p2_score,
    output logic [2:0]         last_scorer,
    output logic               game_over
);

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_SERVE    = 3'd1;
    localparam logic [2:0] ST_PLAY     = 3'd2;
    localparam logic [2:0] ST_SCORED   = 3'd3;
    localparam logic [2:0] ST_GAMEOVER = 3'd4;

    localparam logic [CNT_W-1:0]   SERVE_LOAD = CNT_W'(SERVE_FRAMES - 1);
    localparam logic [CNT_W-1:0]   SCORE_LOAD = CNT_W'(SCORE_FRAMES - 1);
    localparam logic [SCORE_W-1:0] WIN_VAL    = SCORE_W'(WIN_SCORE);

    logic               frame_q_r;
    logic               start_q_r;
    logic               win_q_r;
    logic [2:0]         state_r;
    logic [CNT_W-1:0]   cnt_r;
    logic [SCORE_W-1:0] p1_r;
    logic [SCORE_W-1:0] p2_r;
    logic [2:0]         last_r;
    logic               play_en_r;
    logic               ball_rst_r;
    logic               game_over_r;

    logic               frame_rise_s;
    logic               start_rise_s;
    logic               win_valid_s;
    logic               win_rise_s;
    logic [SCORE_W-1:0] p1_inc_s;
    logic [SCORE_W-1:0] p2_inc_s;
    logic [2:0]         state_nx_s;
    logic [CNT_W-1:0]   cnt_nx_s;
    logic [SCORE_W-1:0] p1_nx_s;
    logic [SCORE_W-1:0] p2_nx_s;
    logic [2:0]         last_nx_s;

    assign frame_rise_s = frame_tick & ~frame_q_r;
    assign start_rise_s = start_btn & ~start_q_r;
    assign win_valid_s  = (winner == 3'd1) || (winner == 3'd2);
    assign win_rise_s   = win_valid_s & ~win_q_r;
    assign p1_inc_s     = p1_r + SCORE_W'(1);
    assign p2_inc_s     = p2_r + SCORE_W'(1);

    // Next-state, countdown and score update for the round sequencer
    always_comb begin
        state_nx_s = state_r;
        cnt_nx_s   = cnt_r;
        p1_nx_s    = p1_r;
        p2_nx_s    = p2_r;
        last_nx_s  = last_r;
        case (state_r)
            ST_IDLE, ST_GAMEOVER: begin
                if (start_rise_s) begin
                    state_nx_s = ST_SERVE;
                    cnt_nx_s   = SERVE_LOAD;
                    p1_nx_s    = {SCORE_W{1'b0}};
                    p2_nx_s    = {SCORE_W{1'b0}};
                    last_nx_s  = 3'd0;
                end else begin
                    state_nx_s = state_r;
                end
            end
            ST_SERVE: begin
                if (frame_rise_s && (cnt_r == {CNT_W{1'b0}})) begin
                    state_nx_s = ST_PLAY;
                end else if (frame_rise_s) begin
                    cnt_nx_s = cnt_r - CNT_W'(1);
                end else begin
                    cnt_nx_s = cnt_r;
                end
            end
            ST_PLAY: begin
                // A score beats a simultaneous frame edge; PLAY ignores frames anyway
                if (win_rise_s && (winner == 3'd1) && (p1_r < WIN_VAL)) begin
                    p1_nx_s   = p1_inc_s;
                    last_nx_s = 3'd1;
                    if (p1_inc_s == WIN_VAL) begin
                        state_nx_s = ST_GAMEOVER;
                    end else begin
                        state_nx_s = ST_SCORED;
                        cnt_nx_s   = SCORE_LOAD;
                    end
                end else if (win_rise_s && (winner == 3'd2) && (p2_r < WIN_VAL)) begin
                    p2_nx_s   = p2_inc_s;
                    last_nx_s = 3'd2;
                    if (p2_inc_s == WIN_VAL) begin
                        state_nx_s = ST_GAMEOVER;
                    end else begin
                        state_nx_s = ST_SCORED;
                        cnt_nx_s   = SCORE_LOAD;
                    end
                end else begin
                    state_nx_s = ST_PLAY;
                end
            end
            ST_SCORED: begin
                if (frame_rise_s && (cnt_r == {CNT_W{1'b0}})) begin
                    state_nx_s = ST_SERVE;
                    cnt_nx_s   = SERVE_LOAD;
                end else if (frame_rise_s) begin
                    cnt_nx_s = cnt_r - CNT_W'(1);
                end else begin
                    cnt_nx_s = cnt_r;
                end
            end
            default: begin
                state_nx_s = ST_IDLE;
                cnt_nx_s   = {CNT_W{1'b0}};
            end
        endcase
    end

    // State, counters, edge flops and outputs decoded from the next state
    always_ff @(posedge clk) begin
        if (!reset) begin
            frame_q_r   <= 1'b0;
            start_q_r   <= 1'b0;
            win_q_r     <= 1'b0;
            state_r     <= ST_IDLE;
            cnt_r       <= {CNT_W{1'b0}};
            p1_r        <= {SCORE_W{1'b0}};
            p2_r        <= {SCORE_W{1'b0}};
            last_r      <= 3'd0;
            play_en_r   <= 1'b0;
            ball_rst_r  <= 1'b1;
            game_over_r <= 1'b0;
        end else begin
            frame_q_r   <= frame_tick;
            start_q_r   <= start_btn;
            win_q_r     <= (winner != 3'd0);
            state_r     <= state_nx_s;
            cnt_r       <= cnt_nx_s;
            p1_r        <= p1_nx_s;
            p2_r        <= p2_nx_s;
            last_r      <= last_nx_s;
            play_en_r   <= (state_nx_s == ST_PLAY);
            ball_rst_r  <= (state_nx_s != ST_PLAY);
            game_over_r <= (state_nx_s == ST_GAMEOVER);
        end
    end

    assign state       = state_r;
    assign play_en     = play_en_r;
    assign ball_rst    = ball_rst_r;
    assign p1_score    = p1_r;
    assign p2_score    = p2_r;
    assign last_scorer = last_r;
    assign game_over   = game_over_r;

endmodule

// File: tb/tb_pong_round_ctrl.sv
// Self-checking bench for pong_round_ctrl: directed game scenarios plus a randomized run
// compared against a phase/frames-left reference model.
module tb_pong_round_ctrl;

    localparam int WIN   = 2;
    localparam int SERVE = 3;
    localparam int SCORE = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       ft  = 1'b0;
    logic       sb  = 1'b0;
    logic [2:0] w   = 3'd0;

    logic [2:0] state;
    logic       play_en;
    logic       ball_rst;
    logic [2:0] p1_score;
    logic [2:0] p2_score;
    logic [2:0] last_scorer;
    logic       game_over;

    int n_tests = 0;
    int n_fail  = 0;

    // reference model: phase 0..4 and the number of frame edges still to wait
    int m_phase = 0;
    int m_left  = 0;
    int m_p1    = 0;
    int m_p2    = 0;
    int m_last  = 0;
    bit m_fq    = 1'b0;
    bit m_sq    = 1'b0;
    bit m_wq    = 1'b0;

    pong_round_ctrl #(
        .WIN_SCORE(WIN), .SERVE_FRAMES(SERVE), .SCORE_FRAMES(SCORE), .SCORE_W(3), .CNT_W(8)
    ) dut (
        .clk(clk), .reset(rst), .frame_tick(ft), .start_btn(sb), .winner(w),
        .state(state), .play_en(play_en), .ball_rst(ball_rst), .p1_score(p1_score),
        .p2_score(p2_score), .last_scorer(last_scorer), .game_over(game_over)
    );

    always #5 clk = ~clk;

    function automatic void model(input bit r, input bit f, input bit s, input int wv);
        bit fr, sr, wr;
        if (!r) begin
            m_phase = 0; m_left = 0; m_p1 = 0; m_p2 = 0; m_last = 0;
            m_fq = 1'b0; m_sq = 1'b0; m_wq = 1'b0;
            return;
        end
        fr = f && !m_fq;
        sr = s && !m_sq;
        wr = (wv == 1 || wv == 2) && !m_wq;
        m_fq = f; m_sq = s; m_wq = (wv != 0);
        if ((m_phase == 0 || m_phase == 4) && sr) begin
            m_phase = 1; m_left = SERVE; m_p1 = 0; m_p2 = 0; m_last = 0;
        end else if (m_phase == 1 && fr) begin
            m_left--;
            if (m_left == 0) m_phase = 2;
        end else if (m_phase == 2 && wr) begin
            if (wv == 1) m_p1++; else m_p2++;
            m_last = wv;
            if (m_p1 == WIN || m_p2 == WIN) m_phase = 4;
            else begin m_phase = 3; m_left = SCORE; end
        end else if (m_phase == 3 && fr) begin
            m_left--;
            if (m_left == 0) begin m_phase = 1; m_left = SERVE; end
        end
    endfunction

    task automatic step();
        @(posedge clk);
        model(rst, ft, sb, int'(w));
        #1;
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) begin
            ft = 1'b1; step();
            ft = 1'b0; step();
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; sb = 1'b1; w = 3'd1;
        step(); step();
        n_tests++;
        if (state !== 3'd0) begin $display("FAIL reset_state: got %0d want 0", state); n_fail++; end
        n_tests++;
        if (p1_score !== 3'd0 || p2_score !== 3'd0) begin
            $display("FAIL reset_scores: got %0d/%0d want 0/0", p1_score, p2_score); n_fail++;
        end
        n_tests++;
        if (ball_rst !== 1'b1 || play_en !== 1'b0 || game_over !== 1'b0) begin
            $display("FAIL reset_flags: ball_rst=%0b play_en=%0b game_over=%0b want 1/0/0",
                     ball_rst, play_en, game_over); n_fail++;
        end
        rst = 1'b1; sb = 1'b0; w = 3'd0;
        step(); step(); step();
        n_tests++;
        if (state !== 3'd0) begin $display("FAIL idle_hold: got %0d want 0", state); n_fail++; end
        sb = 1'b1; step(); step(); step();
        n_tests++;
        if (state !== 3'd1 || last_scorer !== 3'd0) begin
            $display("FAIL start_serve: state=%0d last=%0d want 1/0", state, last_scorer); n_fail++;
        end
        sb = 1'b0; step();
    endtask

    task automatic test_serve();
        frames(1);
        n_tests++;
        if (state !== 3'd1) begin $display("FAIL serve_pulse1: got %0d want 1", state); n_fail++; end
        frames(1);
        n_tests++;
        if (state !== 3'd1) begin $display("FAIL serve_pulse2: got %0d want 1", state); n_fail++; end
        ft = 1'b1; step();
        n_tests++;
        if (state !== 3'd2 || play_en !== 1'b1 || ball_rst !== 1'b0) begin
            $display("FAIL serve_to_play: state=%0d play_en=%0b ball_rst=%0b want 2/1/0",
                     state, play_en, ball_rst); n_fail++;
        end
        ft = 1'b0; step();
    endtask

    task automatic test_p2_hold();
        w = 3'd2; step();
        n_tests++;
        if (p2_score !== 3'd1 || last_scorer !== 3'd2 || state !== 3'd3) begin
            $display("FAIL p2_point: p2=%0d last=%0d state=%0d want 1/2/3",
                     p2_score, last_scorer, state); n_fail++;
        end
        for (int i = 0; i < 499; i++) step();
        n_tests++;
        if (p2_score !== 3'd1 || state !== 3'd3) begin
            $display("FAIL p2_held_once: p2=%0d state=%0d want 1/3", p2_score, state); n_fail++;
        end
        w = 3'd0; step();
        frames(1);
        n_tests++;
        if (state !== 3'd3) begin $display("FAIL scored_pulse1: got %0d want 3", state); n_fail++; end
        frames(1);
        n_tests++;
        if (state !== 3'd1) begin $display("FAIL scored_to_serve: got %0d want 1", state); n_fail++; end
        frames(3);
        n_tests++;
        if (state !== 3'd2) begin $display("FAIL reserve_to_play: got %0d want 2", state); n_fail++; end
    endtask

    task automatic test_gameover();
        w = 3'd1; step(); w = 3'd0; step();
        n_tests++;
        if (p1_score !== 3'd1 || state !== 3'd3) begin
            $display("FAIL p1_first: p1=%0d state=%0d want 1/3", p1_score, state); n_fail++;
        end
        frames(2); frames(3);
        w = 3'd1; step();
        n_tests++;
        if (p1_score !== 3'd2 || state !== 3'd4 || game_over !== 1'b1 || ball_rst !== 1'b1) begin
            $display("FAIL game_over: p1=%0d state=%0d go=%0b br=%0b want 2/4/1/1",
                     p1_score, state, game_over, ball_rst); n_fail++;
        end
        w = 3'd0; step(); w = 3'd2; step(); w = 3'd0; step();
        frames(1);
        n_tests++;
        if (p2_score !== 3'd1 || p1_score !== 3'd2 || state !== 3'd4) begin
            $display("FAIL gameover_hold: p1=%0d p2=%0d state=%0d want 2/1/4",
                     p1_score, p2_score, state); n_fail++;
        end
        sb = 1'b1; step();
        n_tests++;
        if (state !== 3'd1 || p1_score !== 3'd0 || p2_score !== 3'd0 || last_scorer !== 3'd0) begin
            $display("FAIL restart: state=%0d p1=%0d p2=%0d last=%0d want 1/0/0/0",
                     state, p1_score, p2_score, last_scorer); n_fail++;
        end
        sb = 1'b0; step();
    endtask

    task automatic test_ignored();
        frames(3);
        w = 3'd3; step(); step();
        n_tests++;
        if (state !== 3'd2 || p1_score !== 3'd0 || p2_score !== 3'd0) begin
            $display("FAIL winner3_ignored: state=%0d p1=%0d p2=%0d want 2/0/0",
                     state, p1_score, p2_score); n_fail++;
        end
        w = 3'd0; sb = 1'b1; step();
        n_tests++;
        if (state !== 3'd2) begin $display("FAIL start_in_play: got %0d want 2", state); n_fail++; end
        sb = 1'b0; step();
        ft = 1'b1; w = 3'd1; step();
        n_tests++;
        if (p1_score !== 3'd1 || state !== 3'd3 || last_scorer !== 3'd1) begin
            $display("FAIL frame_win_same: p1=%0d state=%0d last=%0d want 1/3/1",
                     p1_score, state, last_scorer); n_fail++;
        end
        ft = 1'b0; w = 3'd0;
    endtask

    task automatic test_reset_mid();
        rst = 1'b0; step();
        n_tests++;
        if (state !== 3'd0 || p1_score !== 3'd0 || last_scorer !== 3'd0 || ball_rst !== 1'b1 ||
            play_en !== 1'b0 || game_over !== 1'b0) begin
            $display("FAIL reset_mid: state=%0d p1=%0d last=%0d br=%0b pe=%0b go=%0b want 0/0/0/1/0/0",
                     state, p1_score, last_scorer, ball_rst, play_en, game_over); n_fail++;
        end
        rst = 1'b1; step();
    endtask

    task automatic test_random();
        int r;
        for (int i = 0; i < 4000; i++) begin
            rst = ($urandom_range(0, 299) != 0);
            ft  = ($urandom_range(0, 2) == 0);
            sb  = ($urandom_range(0, 24) == 0);
            r   = $urandom_range(0, 29);
            w   = (r == 0) ? 3'd1 : (r == 1) ? 3'd2 : (r == 2) ? 3'($urandom_range(3, 7)) : 3'd0;
            step();
            n_tests++;
            if (int'(state) != m_phase || int'(p1_score) != m_p1 || int'(p2_score) != m_p2 ||
                int'(last_scorer) != m_last || play_en !== (m_phase == 2) ||
                ball_rst !== (m_phase != 2) || game_over !== (m_phase == 4)) begin
                $display("FAIL random[%0d]: state=%0d p1=%0d p2=%0d last=%0d pe=%0b br=%0b go=%0b want %0d/%0d/%0d/%0d",
                         i, state, p1_score, p2_score, last_scorer, play_en, ball_rst, game_over,
                         m_phase, m_p1, m_p2, m_last);
                n_fail++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_serve();
        test_p2_hold();
        test_gameover();
        test_ignored();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
